// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency memory reads and
// buffers returned words in a 2-entry FIFO presented to decode over valid/ready.
module fetch_ctrl #(
  parameter int          MEM_WIDTH  = 64,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic                  halted
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;
  localparam logic [31:0] LP_MEM_W = 32'(MEM_WIDTH);

  logic [0:0]                       r_state;
  logic [31:0]                      r_fetch_pc;
  logic                             r_inflight;
  logic [31:0]                      r_inflight_pc;
  logic [1:0][31:0]                 r_fifo_pc;
  logic [1:0][DATA_WIDTH-1:0]       r_fifo_ins;
  logic                             r_wptr;
  logic                             r_rptr;
  logic [1:0]                       r_count;

  logic [2:0] w_used;
  logic       w_pop_raw;
  logic       w_credit;
  logic       w_can;
  logic       w_in_range;
  logic       w_issue;
  logic       w_to_halt;
  logic       w_push;
  logic       w_pop;

  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_fifo_ins[r_rptr];
  assign out_pc    = r_fifo_pc[r_rptr];
  assign halted    = (r_state == ST_HALT);
  assign mem_address = r_fetch_pc;

  // Credit counts the in-flight read as occupied; a same-cycle pop frees one slot.
  assign w_used     = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_pop_raw  = out_valid && out_ready;
  assign w_credit   = (w_used < 3'd2) || ((w_used == 3'd2) && w_pop_raw);
  assign w_can      = (r_state == ST_RUN) && en && !redirect_valid && w_credit;
  assign w_in_range = (r_fetch_pc < LP_MEM_W);
  assign w_issue    = w_can && w_in_range;
  assign w_to_halt  = w_can && !w_in_range;
  assign w_push     = r_inflight && !redirect_valid;
  assign w_pop      = w_pop_raw && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_fifo_pc     <= '0;
      r_fifo_ins    <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
    end else if (redirect_valid) begin
      // Redirect kills the pending response and every buffered entry.
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_state    <= (redirect_pc < LP_MEM_W) ? ST_RUN : ST_HALT;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd1;
      end
      if (w_to_halt) r_state <= ST_HALT;
      if (w_push) begin
        r_fifo_pc[r_wptr]  <= r_inflight_pc;
        r_fifo_ins[r_wptr] <= mem_instruction;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stream, backpressure, redirect, halt, reset, enable.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.MEM_WIDTH(64), .DATA_WIDTH(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_instruction(mem_instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory preloaded with mem[i] = 0x1000_0000 + i, one-cycle registered read.
  always_ff @(posedge clk) mem_instruction <= 32'h1000_0000 + mem_address;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " pc"},    64'(out_pc), 64'(pc));
    check({tag, " instr"}, 64'(out_instr), 64'(32'h1000_0000 + pc));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    step();
    check("rst valid", 64'(out_valid), 64'd0);
    check("rst addr",  64'(mem_address), 64'd0);
    check("rst halted", 64'(halted), 64'd0);
    check("rst instr", 64'(out_instr), 64'd0);
    check("rst pc",    64'(out_pc), 64'd0);
    rst_n = 1'b1;

    // First issue edge: nothing visible yet.
    step();
    check("lat valid", 64'(out_valid), 64'd0);
    check("lat addr",  64'(mem_address), 64'd1);
    for (int k = 0; k <= 4; k++) begin
      step();
      check_head("stream", 32'(k));
      check("stream addr", 64'(mem_address), 64'(k + 2));
    end

    // Backpressure with pc 4 at the head.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_head("bp hold", 32'd4);
      check("bp addr", 64'(mem_address), 64'd6);
    end
    out_ready = 1'b1;
    for (int k = 5; k <= 6; k++) begin
      step();
      check_head("bp resume", 32'(k));
    end
    check("bp resume addr", 64'(mem_address), 64'd8);

    // Redirect with 6 buffered and 7 in flight; pop same cycle is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    step();
    redirect_valid = 1'b0;
    check("redir valid", 64'(out_valid), 64'd0);
    check("redir addr",  64'(mem_address), 64'd20);
    step();
    check("redir valid2", 64'(out_valid), 64'd0);
    check("redir addr2",  64'(mem_address), 64'd21);
    for (int k = 20; k <= 63; k++) begin
      step();
      check_head("run", 32'(k));
      check("run halted", 64'(halted), 64'(k == 63));
    end
    step();
    check("end valid",  64'(out_valid), 64'd0);
    check("end halted", 64'(halted), 64'd1);
    check("end addr",   64'(mem_address), 64'd64);
    step();
    check("end addr2",  64'(mem_address), 64'd64);
    check("end valid2", 64'(out_valid), 64'd0);

    // Redirect out of HALT back to 0.
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    check("unhalt halted", 64'(halted), 64'd0);
    check("unhalt valid",  64'(out_valid), 64'd0);
    check("unhalt addr",   64'(mem_address), 64'd0);
    step();
    check("unhalt valid2", 64'(out_valid), 64'd0);
    check("unhalt addr2",  64'(mem_address), 64'd1);
    step();
    check_head("unhalt", 32'd0);

    // Out-of-range redirect.
    redirect_valid = 1'b1; redirect_pc = 32'd100;
    step();
    redirect_valid = 1'b0;
    check("oor halted", 64'(halted), 64'd1);
    check("oor valid",  64'(out_valid), 64'd0);
    check("oor addr",   64'(mem_address), 64'd100);
    step();
    check("oor halted2", 64'(halted), 64'd1);
    check("oor valid2",  64'(out_valid), 64'd0);
    check("oor addr2",   64'(mem_address), 64'd100);

    // Restart, fill two entries, then reset mid-stream.
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    check_head("refill", 32'd0);
    out_ready = 1'b0;
    step();
    check_head("full", 32'd0);
    check("full addr", 64'(mem_address), 64'd2);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    check("mrst valid", 64'(out_valid), 64'd0);
    check("mrst addr",  64'(mem_address), 64'd0);
    check("mrst halted", 64'(halted), 64'd0);
    step();
    check("mrst lat", 64'(out_valid), 64'd0);
    step();
    check_head("mrst s0", 32'd0);
    step();
    check_head("mrst s1", 32'd1);
    check("mrst addr3", 64'(mem_address), 64'd3);

    // Enable low: PC freezes, in-flight response is still delivered.
    en = 1'b0;
    step();
    check_head("en drain", 32'd2);
    check("en addr", 64'(mem_address), 64'd3);
    step();
    check("en empty", 64'(out_valid), 64'd0);
    check("en addr2", 64'(mem_address), 64'd3);
    en = 1'b1;
    step();
    check("en issue valid", 64'(out_valid), 64'd0);
    check("en issue addr",  64'(mem_address), 64'd4);
    step();
    check_head("en resume", 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
